logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, multi-cycle bitwise logic unit for the ALU, generalising the fixed 32-bit inverter to eight selectable bitwise operations over a configurable word width. It processes the operands CHUNK bits per cycle, LSB chunk first, behind a valid/ready handshake on both sides. It also produces a zero flag. It sits beside the adder and shifter in the ALU and is issued by the execute stage for logic opcodes.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK is the compute cycle count.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  operation select (encodings below).
- data_a  input  WIDTH  operand A.
- data_b  input  WIDTH  operand B (ignored for NOT and PASS).
- out_valid  output  1  result and is_zero valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- is_zero  output  1  high when the result equals 0.

## Operation
- Op encodings: 000 NOT A, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS A. All 8 codes are defined.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch data_a, data_b and op. Clear result to 0. Set zero accumulator to 1. Set chunk counter cnt=0. Go to BUSY.
- BUSY:
  - Each cycle, compute chunk cnt, which is bits [cnt*CHUNK +: CHUNK], from the latched operands.
  - Write that chunk into result.
  - Update is_zero_acc &= (chunk == 0).
  - Increment cnt.
  - When cnt == N-1 is processed, go to DONE.
  - Input changes are ignored in BUSY because operands are latched.
- DONE:
  - out_valid=1. result and is_zero are held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle re-accept.
- Counter width is clog2(N), minimum 1. cnt never exceeds N-1. It resets to 0 on each accept.
- Reset at any time, including mid-BUSY or in DONE, aborts the operation immediately.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, is_zero=0, cnt=0, latched operands=0.
- out_ready asserted outside DONE has no effect. in_valid outside IDLE has no effect, and the producer must hold it until in_ready.

## Timing
- Accept on edge k, when in_valid & in_ready are sampled high.
- BUSY occupies the cycles after edges k..k+N-1.
- Edge k+N enters DONE. out_valid is first visible after edge k+N, giving a latency of N cycles (4 at defaults).
- Throughput is at most one operation per N+2 cycles, with out_ready held high.
- result is partially updated during BUSY and is meaningful only while out_valid=1.
- All outputs are registered, with no combinational input-to-output path. in_ready and out_valid decode directly from the state register.

## Structure
- alu_pkg holds:
  - the op encoding constants (OP_NOT … OP_PASS);
  - the FSM state encodings (S_IDLE, S_BUSY, S_DONE).
- Sub-module logic_chunk (parameter CHUNK) is combinational: inputs a, b, op; output y. The top instantiates one copy and muxes the chunk slice in by cnt.
- The top holds the FSM, counter, operand latches, result register and zero accumulator.

## Test plan
- NOT, defaults: op=000, A=32'h0000_FFFF → after 4 cycles result=32'hFFFF_0000, is_zero=0, out_valid stays high until out_ready.
- Full op sweep: A=32'hF0F0_1234, B=32'h0FF0_FF00 for each of the 8 ops → result matches the bitwise reference. XOR=32'hFF00_ED34, AND=32'h00F0_1200.
- Zero flag: XOR with A=B=32'hDEAD_BEEF → result=0, is_zero=1. Chunk-boundary check: A=32'h8000_0000 PASS → is_zero=0, with the nonzero bit only in the last chunk.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 → IDLE on the next edge, in_ready=1.
- Reset mid-BUSY: assert reset after 2 BUSY cycles → immediately out_valid=0, result=0, in_ready=1. The next op, NOR 0,0, gives 32'hFFFF_FFFF.
- Parameter variants: WIDTH=16, CHUNK=16 (N=1, latency 1) and WIDTH=64, CHUNK=4 (N=16) → correct results for NOT and XNOR with random operands. Latency equals N.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU logic unit: operation select and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_chunk.sv
// Combinational bitwise operation on one CHUNK-wide slice of the operands.
module logic_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [2:0]       op,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// Multi-cycle bitwise logic unit: latches operands, then computes one CHUNK
// per cycle LSB first, accumulating a zero flag, and holds the result in DONE.
module logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             is_zero,
    output logic [1:0]       fsm_state
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q, result_q;
    logic [2:0]         op_q;
    logic               zero_acc;
    logic [CHUNK-1:0]   a_chunk, b_chunk, y_chunk;
    int unsigned        shamt;

    // Handshakes: a transfer happens on an edge where valid and ready are both
    // high; in_ready is high only in IDLE and out_valid only in DONE, so no
    // transfer can be accepted and completed in the same cycle.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign is_zero   = zero_acc;
    assign fsm_state = state_q;

    assign shamt   = int'(cnt) * CHUNK;
    assign a_chunk = CHUNK'(a_q >> shamt);
    assign b_chunk = CHUNK'(b_q >> shamt);

    logic_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .op (op_q),
        .y  (y_chunk)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)    state_d = S_BUSY;
            S_BUSY:  if (cnt == LAST) state_d = S_DONE;
            S_DONE:  if (out_ready)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_acc <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q      <= data_a;
                    b_q      <= data_b;
                    op_q     <= op;
                    result_q <= '0;
                    zero_acc <= 1'b1;
                    cnt      <= '0;
                end
                S_BUSY: begin
                    // Read-modify-write of just the active slice.
                    result_q <= (result_q & ~(MASK << shamt)) | (WIDTH'(y_chunk) << shamt);
                    zero_acc <= zero_acc & (y_chunk == '0);
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit: vector table at default width plus
// backpressure, reset-abort and parameter-variant sequences.
module tb_logic_unit;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        in_ready, out_valid, is_zero;
    logic [31:0] result;
    logic [1:0]  fsm_state;

    logic        v16_in_valid = 1'b0, v16_out_ready = 1'b0;
    logic [2:0]  v16_op = '0;
    logic [15:0] v16_a = '0, v16_b = '0, v16_result;
    logic        v16_in_ready, v16_out_valid, v16_zero;
    logic [1:0]  v16_state;

    logic        v64_in_valid = 1'b0, v64_out_ready = 1'b0;
    logic [2:0]  v64_op = '0;
    logic [63:0] v64_a = '0, v64_b = '0, v64_result;
    logic        v64_in_ready, v64_out_valid, v64_zero;
    logic [1:0]  v64_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    logic_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .data_a(data_a), .data_b(data_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .is_zero(is_zero), .fsm_state(fsm_state)
    );

    logic_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clock(clock), .reset(reset), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
        .op(v16_op), .data_a(v16_a), .data_b(v16_b), .out_valid(v16_out_valid),
        .out_ready(v16_out_ready), .result(v16_result), .is_zero(v16_zero), .fsm_state(v16_state)
    );

    logic_unit #(.WIDTH(64), .CHUNK(4)) dut64 (
        .clock(clock), .reset(reset), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .op(v64_op), .data_a(v64_a), .data_b(v64_b), .out_valid(v64_out_valid),
        .out_ready(v64_out_ready), .result(v64_result), .is_zero(v64_zero), .fsm_state(v64_state)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op = o; data_a = a; data_b = b; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        // Scramble inputs so any failure to latch shows up in the result.
        op = 3'($urandom); data_a = $urandom; data_b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({name, " in_ready after release"}, 64'(in_ready), 64'd1);
        check({name, " out_valid after release"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_var(input bit big, input logic [2:0] o, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp);
        int lat;
        string nm;
        nm = big ? "w64" : "w16";
        @(negedge clock);
        if (big) begin v64_op = o; v64_a = a; v64_b = b; v64_in_valid = 1'b1; end
        else     begin v16_op = o; v16_a = a[15:0]; v16_b = b[15:0]; v16_in_valid = 1'b1; end
        @(posedge clock);
        #1;
        v64_in_valid = 1'b0;
        v16_in_valid = 1'b0;
        lat = 0;
        while (!(big ? v64_out_valid : v16_out_valid) && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check($sformatf("%s op%0d latency", nm, o), 64'(lat), big ? 64'd16 : 64'd1);
        check($sformatf("%s op%0d result", nm, o), big ? v64_result : {48'h0, v16_result}, exp);
        check($sformatf("%s op%0d is_zero", nm, o), 64'(big ? v64_zero : v16_zero), 64'(exp == 64'h0));
        @(negedge clock);
        v64_out_ready = 1'b1;
        v16_out_ready = 1'b1;
        @(posedge clock);
        #1;
        v64_out_ready = 1'b0;
        v16_out_ready = 1'b0;
        check($sformatf("%s in_ready after release", nm), 64'(big ? v64_in_ready : v16_in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [63:0] a64, b64;
        logic [15:0] a16, b16;

        vecs.push_back('{OP_NOT,  32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{OP_NOT,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h0F0F_EDCB, 1'b0});
        vecs.push_back('{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0});
        vecs.push_back('{OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0});
        vecs.push_back('{OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0});
        vecs.push_back('{OP_NAND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF0F_EDFF, 1'b0});
        vecs.push_back('{OP_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0});
        vecs.push_back('{OP_XNOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00FF_12CB, 1'b0});
        vecs.push_back('{OP_PASS, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hF0F0_1234, 1'b0});
        vecs.push_back('{OP_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
        vecs.push_back('{OP_PASS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
        vecs.push_back('{OP_NOT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{OP_AND,  32'h0000_00FF, 32'hFFFF_FF00, 32'h0000_0000, 1'b1});

        // Reset values
        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset is_zero", 64'(is_zero), 64'd0);
        check("reset state", 64'(fsm_state), 64'(S_IDLE));
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d in_ready busy", i), 64'(in_ready), 64'd0);
            wait_done(lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'd4);
            check($sformatf("v%0d result", i), 64'(result), 64'(vecs[i].exp_r));
            check($sformatf("v%0d is_zero", i), 64'(is_zero), 64'(vecs[i].exp_z));
            release_result($sformatf("v%0d", i));
        end

        // Backpressure in DONE with in_valid pulses that must be ignored
        issue(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00);
        wait_done(lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            in_valid = 1'b1; op = OP_AND; data_a = $urandom; data_b = $urandom;
            @(posedge clock);
            #1;
            check($sformatf("bp%0d result", c), 64'(result), 64'hFF00_ED34);
            check($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset after two BUSY cycles aborts at once
        issue(OP_PASS, 32'hFFFF_FFFF, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort state", 64'(fsm_state), 64'(S_IDLE));
        @(negedge clock);
        reset = 1'b0;
        issue(OP_NOR, 32'h0, 32'h0);
        wait_done(lat);
        check("post-abort latency", 64'(lat), 64'd4);
        check("post-abort result", 64'(result), 64'hFFFF_FFFF);
        check("post-abort is_zero", 64'(is_zero), 64'd0);
        release_result("post-abort");

        // Parameter variants
        for (int r = 0; r < 3; r++) begin
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            run_var(1'b1, OP_NOT,  a64, b64, ~a64);
            run_var(1'b1, OP_XNOR, a64, b64, ~(a64 ^ b64));
            run_var(1'b0, OP_NOT,  {48'h0, a16}, {48'h0, b16}, {48'h0, ~a16});
            run_var(1'b0, OP_XNOR, {48'h0, a16}, {48'h0, b16}, {48'h0, ~(a16 ^ b16)});
        end
        run_var(1'b0, OP_XNOR, 64'h1234, 64'hEDCB, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
